vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//  Upstream feeder for the 800x600 VGA timing/output stage. Reads RGB444 pixels
//  from the framebuffer over a pipelined read port and buffers them in a small FIFO.
//  Presents one pixel per pix_req during active video. Each frame restarts on frame_start.
// PARAMETERS
//  H_ACTIVE    800     active pixels per line
//  V_ACTIVE    600     active lines per frame
//  FIFO_DEPTH  16      pixel FIFO entries, power of two, >=4
//  ADDR_W      19      framebuffer address width; must hold H_ACTIVE*V_ACTIVE
//  PIXEL_W     12      {R[3:0],G[3:0],B[3:0]}
// PORTS
//  MAX10_CLK1_50  in   1        sole clock; all logic on its rising edge
//  RESET          in   1        asynchronous, active-high reset
//  frame_start    in   1        1-cycle pulse from timing stage during vertical blanking
//  pix_req        in   1        timing stage consumes one pixel this cycle
//  pix_data       out  PIXEL_W  FIFO head (first-word fall-through); 0 when empty
//  pix_valid      out  1        FIFO non-empty
//  underflow      out  1        sticky: pix_req seen while FIFO empty
//  mem_rd         out  1        read strobe; one address accepted per asserted cycle
//  mem_addr       out  ADDR_W   linear pixel address, valid with mem_rd
//  mem_rdata      in   PIXEL_W  read data
//  mem_rvalid     in   1        mem_rdata valid; in-order; latency >=1, variable
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, addr=0, outstanding=0, discard=0.
//   Outputs: mem_rd=0, mem_addr=0, pix_valid=0, pix_data=0, underflow=0.
//  FSM:
//   IDLE  -> FETCH on frame_start.
//   FETCH -> DRAIN when the read for address H_ACTIVE*V_ACTIVE-1 is issued.
//   DRAIN -> FETCH on frame_start.
//   frame_start in any state: flush FIFO, addr=0, go to FETCH.
//  Read issue (FETCH only):
//   mem_rd=1 iff fifo_count + outstanding < FIFO_DEPTH.
//   On each issue, addr increments by 1. addr never wraps; it stops at the last pixel.
//   outstanding += mem_rd, -= mem_rvalid. Both in the same cycle: net 0.
//  Flush: discard := outstanding (counting the same-cycle mem_rd/mem_rvalid).
//   While discard>0, each mem_rvalid decrements discard and is dropped, not pushed.
//   mem_rd is held 0 until discard==0, so no stale data enters a new frame.
//  FIFO:
//   Push on mem_rvalid (not discarded). Pop on pix_req && pix_valid.
//   Push and pop in the same cycle: count unchanged, legal at full and at empty+push.
//   Overflow is impossible by the credit rule. Any push at full is an RTL bug (assertion).
//   Latency mem_rvalid -> pix_valid: 1 cycle.
//  Underflow:
//   pix_req && !pix_valid sets underflow, with pix_data=0 (black); no pop.
//   underflow clears only on RESET.
//  Widths: fifo_count is $clog2(FIFO_DEPTH)+1 bits; outstanding and discard are the same width.
//  Reset mid-frame: everything returns to reset values immediately. In-flight memory
//   responses after reset deassertion are ignored until frame_start, because IDLE
//   never pushes.
//  pix_req outside FETCH/DRAIN while empty still sets underflow.
// STRUCTURE
//  Shared package vga_pkg: H_ACTIVE, V_ACTIVE, PIXEL_W, the FETCH/DRAIN/IDLE state
//   encoding, and the FB_PIXELS = H_ACTIVE*V_ACTIVE localparam.
//  One sub-module: pixel_fifo (sync FWFT FIFO; push, pop, count, full, empty).
//  Top level holds the FSM, the address counter and the outstanding/discard counters.
// TESTING
//  1 RESET mid-FETCH with 5 reads outstanding -> all outputs 0 next cycle; IDLE;
//    late mem_rvalid ignored.
//  2 frame_start, fixed memory latency 3, no pix_req -> exactly 16 reads (addr 0..15);
//    pix_valid after first return; mem_rd stays 0 once full.
//  3 pix_req every cycle after fill, latency 3 -> pixels 0,1,2,... in order;
//    underflow stays 0 through 800 pixels.
//  4 Stream to the end of the frame -> last mem_addr=479999; state DRAIN;
//    no further mem_rd; FIFO drains to empty.
//  5 frame_start with 4 reads outstanding -> 4 responses dropped;
//    first pushed pixel comes from addr 0.
//  6 pix_req on empty FIFO -> pix_data=0, underflow=1 and held until RESET.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and pixel type for the VGA pixel fetch path.
// Frame geometry defaults to 800x600 RGB444.
package vga_pkg;

    localparam int unsigned H_ACTIVE   = 800;
    localparam int unsigned V_ACTIVE   = 600;
    localparam int unsigned FB_PIXELS  = H_ACTIVE * V_ACTIVE;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned PIXEL_W    = 12;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; the head reads as zero when empty.
// A push at full is accepted only together with a pop.
module pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 12,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en_s, rd_en_s;

    // Occupancy flags, enables and next pointer/count values.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == {CNT_W{1'b0}});
        rd_en_s  = pop && !flush && !empty;
        wr_en_s  = push && !flush && (!full || rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_s);
            count_d  = count_q + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
        end
        rdata = empty ? {W{1'b0}} : store_q[rd_ptr_q];
        count = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pixel storage; contents are masked by empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            store_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vga_pixel_fetch_chk.sv
// Runtime checks for the pixel fetch block: the credit scheme must never
// let a memory response arrive at a full FIFO without a matching pop.
module vga_pixel_fetch_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer reader feeding the VGA timing stage: credit-limited pipelined reads,
// stale-response discard after a frame restart, and a FWFT pixel FIFO.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned H_PIX   = H_ACTIVE,
    parameter int unsigned V_LINES = V_ACTIVE
) (
    input  logic               MAX10_CLK1_50,
    input  logic               RESET,
    input  logic               frame_start,
    input  logic               pix_req,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_valid,
    output logic               underflow,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIXEL_W-1:0] mem_rdata,
    input  logic               mem_rvalid
);

    localparam int unsigned       FRAME_PIX = H_PIX * V_LINES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic              underflow_q, underflow_d;

    logic [CNT_W:0]    credit_sum_s;
    logic [CNT_W:0]    out_sum_s;
    logic              mem_rd_s;
    logic              fifo_push_s, fifo_pop_s, fifo_flush_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s, fifo_empty_s;
    pixel_t            fifo_head_s;

    // Read issue and in-flight accounting; a response with nothing in flight
    // (left over from before a reset) must not wrap the counter.
    always_comb begin
        credit_sum_s = {1'b0, fifo_count_s} + {1'b0, outstanding_q};
        mem_rd_s     = (state_q == ST_FETCH) && (discard_q == {CNT_W{1'b0}})
                       && (credit_sum_s < (CNT_W + 1)'(FIFO_DEPTH));
        out_sum_s    = {1'b0, outstanding_q} + (CNT_W + 1)'(mem_rd_s);
        if (mem_rvalid && (out_sum_s != {(CNT_W + 1){1'b0}})) begin
            outstanding_d = CNT_W'(out_sum_s - (CNT_W + 1)'(1));
        end else begin
            outstanding_d = out_sum_s[CNT_W-1:0];
        end
    end

    // Frame FSM, address counter, discard counter and FIFO control.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        discard_d    = discard_q;
        fifo_flush_s = 1'b0;
        fifo_pop_s   = pix_req && !fifo_empty_s;
        fifo_push_s  = mem_rvalid && (discard_q == {CNT_W{1'b0}}) && (state_q != ST_IDLE);
        underflow_d  = underflow_q || (pix_req && fifo_empty_s);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (mem_rd_s && (addr_q == LAST_ADDR)) begin
                    state_d = ST_DRAIN;
                end else if (mem_rd_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((discard_q != {CNT_W{1'b0}}) && mem_rvalid) begin
            discard_d = discard_q - CNT_W'(1);
        end else begin
            discard_d = discard_q;
        end

        // A restart wins over everything: every read still in flight becomes stale.
        if (frame_start) begin
            fifo_flush_s = 1'b1;
            addr_d       = {ADDR_W{1'b0}};
            state_d      = ST_FETCH;
            discard_d    = outstanding_d;
        end else begin
            fifo_flush_s = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            addr_q        <= {ADDR_W{1'b0}};
            outstanding_q <= {CNT_W{1'b0}};
            discard_q     <= {CNT_W{1'b0}};
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            underflow_q   <= underflow_d;
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIXEL_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (MAX10_CLK1_50),
        .rst   (RESET),
        .flush (fifo_flush_s),
        .push  (fifo_push_s),
        .wdata (mem_rdata),
        .pop   (fifo_pop_s),
        .rdata (fifo_head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    vga_pixel_fetch_chk u_chk (
        .clk   (MAX10_CLK1_50),
        .rst   (RESET),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .flush (fifo_flush_s),
        .full  (fifo_full_s)
    );

    assign mem_rd    = mem_rd_s;
    assign mem_addr  = addr_q;
    assign pix_data  = fifo_head_s;
    assign pix_valid = !fifo_empty_s;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a reduced 40x30 frame: queue-based reference model,
// in-order variable-latency memory, directed scenarios and literal spot checks.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    localparam int H_T  = 40;
    localparam int V_T  = 30;
    localparam int FB_T = H_T * V_T;

    logic                clk = 1'b0;
    logic                rst;
    logic                frame_start, pix_req, mem_rvalid;
    logic [PIXEL_W-1:0]  pix_data, mem_rdata;
    logic                pix_valid, underflow, mem_rd;
    logic [ADDR_W-1:0]   mem_addr;

    always #10 clk = ~clk;

    vga_pixel_fetch #(.H_PIX(H_T), .V_LINES(V_T)) dut (
        .MAX10_CLK1_50 (clk),
        .RESET         (rst),
        .frame_start   (frame_start),
        .pix_req       (pix_req),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .underflow     (underflow),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 fetching, 2 draining.
    int          m_phase, m_infl, m_disc, m_addr;
    bit          m_under;
    logic [11:0] m_fifo[$];

    typedef struct packed { int due; logic [11:0] data; } resp_t;
    resp_t mq[$];
    int    mem_lat  = 3;
    bit    rand_lat = 1'b0;
    int    last_due = 0;

    int cyc = 0;
    int rd_cnt = 0, rv_cnt = 0, last_rd_addr = -1, pop_idx = 0;
    bit chk_order = 1'b0;

    function automatic logic [11:0] pix_of(input int a);
        return 12'(a * 37 + 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick(input bit fs, input bit req);
        bit          e_rd, rv, push;
        logic [11:0] rdat;
        resp_t       r;
        int          lat, due, infl_sum;
        e_rd = (m_phase == 1) && (m_disc == 0) && ((m_fifo.size() + m_infl) < 16);
        check("mem_rd", 32'(mem_rd), 32'(e_rd));
        if (e_rd) check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("pix_valid", 32'(pix_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) check("pix_data", 32'(pix_data), 32'(m_fifo[0]));
        else                   check("pix_data_empty", 32'(pix_data), 32'd0);
        check("underflow", 32'(underflow), 32'(m_under));
        if (chk_order && req && pix_valid) begin
            check("pix_order", 32'(pix_data), 32'(pix_of(pop_idx)));
        end
        if (req && pix_valid) pop_idx++;

        if (mem_rd) begin
            rd_cnt++;
            last_rd_addr = int'(mem_addr);
            lat = rand_lat ? int'($urandom_range(1, 5)) : mem_lat;
            due = cyc + 1 + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{due: due, data: pix_of(int'(mem_addr))});
        end
        rv   = 1'b0;
        rdat = 12'hBAD;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            r    = mq.pop_front();
            rv   = 1'b1;
            rdat = r.data;
            rv_cnt++;
        end
        frame_start = fs;
        pix_req     = req;
        mem_rvalid  = rv;
        mem_rdata   = rdat;

        push     = rv && (m_disc == 0) && (m_phase != 0);
        if (rv && m_disc > 0) m_disc--;
        infl_sum = m_infl + int'(e_rd);
        m_infl   = (rv && infl_sum > 0) ? infl_sum - 1 : infl_sum;
        if (req && m_fifo.size() > 0) void'(m_fifo.pop_front());
        else if (req) m_under = 1'b1;
        if (push) m_fifo.push_back(rdat);
        if (e_rd) begin
            if (m_addr == FB_T - 1) m_phase = 2;
            else m_addr++;
        end
        if (fs) begin
            m_fifo.delete();
            m_addr  = 0;
            m_phase = 1;
            m_disc  = m_infl;
            pop_idx = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 1'b0; pix_req = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        m_phase = 0; m_infl = 0; m_disc = 0; m_addr = 0; m_under = 1'b0;
        m_fifo.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_edge, first_valid, guard, stalls, vcnt, rd_before;
        rst = 1'b1; frame_start = 1'b0; pix_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 12'h000;
        @(negedge clk);
        do_reset();

        // Fill from frame start: exactly one FIFO's worth of reads, no consumer.
        mem_lat = 3;
        rd_cnt  = 0;
        tick(1'b1, 1'b0);
        fs_edge     = cyc;
        first_valid = -1;
        repeat (30) begin
            if (pix_valid && first_valid < 0) first_valid = cyc;
            tick(1'b0, 1'b0);
        end
        check("fill_first_valid_lat", 32'(first_valid - fs_edge), 32'd4);
        check("fill_rd_count", 32'(rd_cnt), 32'd16);
        check("fill_last_addr", 32'(last_rd_addr), 32'd15);
        check("fill_rd_idle", 32'(mem_rd), 32'd0);
        check("fill_head", 32'(pix_data), 32'(12'd5));

        // Continuous consumption of 800 pixels.
        chk_order = 1'b1;
        guard = 0; stalls = 0;
        while (pop_idx < 800 && guard < 2000) begin
            if (!pix_valid) stalls++;
            tick(1'b0, pix_valid);
            guard++;
        end
        check("stream_pops", 32'(pop_idx), 32'd800);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_underflow", 32'(underflow), 32'd0);

        // Run to the end of the frame and drain.
        guard = 0;
        while (pop_idx < FB_T && guard < 3000) begin
            tick(1'b0, pix_valid);
            guard++;
        end
        check("frame_pops", 32'(pop_idx), 32'(FB_T));
        check("frame_last_addr", 32'(last_rd_addr), 32'(FB_T - 1));
        check("frame_rd_total", 32'(rd_cnt), 32'(FB_T));
        rd_before = rd_cnt;
        repeat (10) tick(1'b0, 1'b0);
        check("drain_no_rd", 32'(rd_cnt), 32'(rd_before));
        check("drain_empty", 32'(pix_valid), 32'd0);
        check("drain_underflow", 32'(underflow), 32'd0);

        // Reset in the middle of a fetch with five reads in flight.
        chk_order = 1'b0;
        mem_lat = 6;
        tick(1'b1, 1'b0);
        rd_cnt = 0;
        repeat (5) tick(1'b0, 1'b0);
        check("midrst_inflight", 32'(rd_cnt), 32'd5);
        do_reset();
        vcnt = 0;
        rv_cnt = 0;
        repeat (12) begin
            if (pix_valid || mem_rd) vcnt++;
            tick(1'b0, 1'b0);
        end
        check("midrst_late_ignored", 32'(vcnt), 32'd0);
        check("midrst_late_arrived", 32'(rv_cnt), 32'd5);

        // Restart with four reads in flight: their data must be dropped.
        tick(1'b1, 1'b0);
        rd_cnt = 0;
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("restart_inflight", 32'(rd_cnt), 32'd4);
        rv_cnt = 0;
        guard = 0;
        while (!mem_rd && guard < 40) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        check("restart_dropped", 32'(rv_cnt), 32'd4);
        check("restart_empty", 32'(pix_valid), 32'd0);
        guard = 0;
        while (!pix_valid && guard < 40) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        check("restart_first_pixel", 32'(pix_data), 32'(12'd5));

        // Variable latency with an irregular consumer.
        chk_order = 1'b1;
        rand_lat  = 1'b1;
        guard = 0;
        while (pop_idx < 300 && guard < 3000) begin
            tick(1'b0, pix_valid && ($urandom_range(0, 3) != 0));
            guard++;
        end
        check("randlat_pops", 32'(pop_idx), 32'd300);
        check("randlat_underflow", 32'(underflow), 32'd0);

        // Request on an empty FIFO: black pixel, sticky underflow.
        chk_order = 1'b0;
        do_reset();
        tick(1'b0, 1'b1);
        check("uf_set", 32'(underflow), 32'd1);
        check("uf_black", 32'(pix_data), 32'd0);
        repeat (12) tick(1'b0, 1'b0);
        rand_lat = 1'b0;
        mem_lat  = 3;
        tick(1'b1, 1'b0);
        repeat (30) tick(1'b0, pix_valid);
        check("uf_sticky", 32'(underflow), 32'd1);
        do_reset();
        tick(1'b0, 1'b0);
        check("uf_cleared", 32'(underflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
